// File: rtl/typedefs.sv
// Types shared by the rename / issue / execute slice of the core.
package typedefs;

  localparam int unsigned PregIdxW = 6;
  localparam int unsigned IQ_DEPTH = 8;

  typedef logic [PregIdxW-1:0] preg_idx_t;

  typedef struct packed {
    logic      valid;
    logic      ready;
    preg_idx_t idx;
  } src_t;

  typedef struct packed {
    logic        valid;
    preg_idx_t   rd;
    logic [15:0] imm;
    src_t        rs1;
    src_t        rs2;
  } rinstr_t;

  typedef struct packed {
    logic      valid;
    preg_idx_t idx;
  } p_reg_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

  // An unused source never blocks issue.
  function automatic logic src_ready(src_t s);
    return !s.valid || s.ready;
  endfunction

  function automatic src_t src_wake(src_t s, p_reg_t wb);
    src_t r;
    r = s;
    if (wb.valid && s.valid && (s.idx == wb.idx)) begin
      r.ready = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_select.sv
// Lowest-index-first priority encoder over the issue queue eligibility vector.
module iq_select #(
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH-1:0]         eligible_i,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     found_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        idx_o   = IdxW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue: oldest ready instruction issues first,
// sources woken by the physical-register broadcast, flushed on mispredict.
module issue_queue
  import typedefs::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  rinstr_t                    rinstr_i,
  input  p_reg_t                     p_wb_i,
  input  br_result_t                 br_result_i,
  input  logic                       issue_ready_i,
  output rinstr_t                    iinstr_o,
  output logic                       iq_full_o,
  output logic [$clog2(DEPTH+1)-1:0] iq_count_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  rinstr_t ent_q [DEPTH];
  rinstr_t ent_d [DEPTH];
  rinstr_t woke  [DEPTH];
  rinstr_t new_ent;

  logic [DEPTH-1:0] occ_q, occ_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             held_q, held_d;
  logic [IdxW-1:0]  held_idx_q, held_idx_d;

  logic [DEPTH-1:0] eligible;
  logic [IdxW-1:0]  found_idx, sel_idx;
  logic [CntW-1:0]  alloc_slot;
  logic             found, flush, offer, issue, alloc;

  // Eligibility looks only at registered state, so a same-cycle wakeup waits a cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      eligible[i] = occ_q[i] && src_ready(ent_q[i].rs1) && src_ready(ent_q[i].rs2);
    end
  end

  iq_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .eligible_i (eligible),
    .idx_o      (found_idx),
    .found_o    (found)
  );

  assign flush      = br_result_i.valid && !br_result_i.hit;
  // A pending offer is pinned so an older wakeup cannot swap it out.
  assign sel_idx    = held_q ? held_idx_q : found_idx;
  assign offer      = (held_q || found) && !flush;
  assign issue      = offer && issue_ready_i;
  assign iq_full_o  = (count_q == CntW'(DEPTH));
  assign alloc      = rinstr_i.valid && !iq_full_o && !flush;
  assign iq_count_o = count_q;

  always_comb begin
    iinstr_o = '0;
    if (offer) begin
      iinstr_o       = ent_q[sel_idx];
      iinstr_o.valid = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      woke[i]     = ent_q[i];
      woke[i].rs1 = src_wake(ent_q[i].rs1, p_wb_i);
      woke[i].rs2 = src_wake(ent_q[i].rs2, p_wb_i);
    end

    new_ent     = rinstr_i;
    new_ent.rs1 = src_wake(rinstr_i.rs1, p_wb_i);
    new_ent.rs2 = src_wake(rinstr_i.rs2, p_wb_i);

    // Collapse everything above the issued slot down by one.
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (issue && (IdxW'(i) >= sel_idx)) begin
        ent_d[i] = woke[i+1];
        occ_d[i] = occ_q[i+1];
      end else begin
        ent_d[i] = woke[i];
        occ_d[i] = occ_q[i];
      end
    end
    if (issue) begin
      ent_d[DEPTH-1] = '0;
      occ_d[DEPTH-1] = 1'b0;
    end else begin
      ent_d[DEPTH-1] = woke[DEPTH-1];
      occ_d[DEPTH-1] = occ_q[DEPTH-1];
    end

    alloc_slot = count_q - CntW'(issue);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (alloc && (CntW'(i) == alloc_slot)) begin
        ent_d[i] = new_ent;
        occ_d[i] = 1'b1;
      end
    end

    count_d = count_q + CntW'(alloc) - CntW'(issue);

    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_d[i] = '0;
      end
      occ_d   = '0;
      count_d = '0;
    end

    held_d     = offer && !issue_ready_i;
    held_idx_d = sel_idx;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      occ_q      <= '0;
      count_q    <= '0;
      held_q     <= 1'b0;
      held_idx_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= ent_d[i];
      end
      occ_q      <= occ_d;
      count_q    <= count_d;
      held_q     <= held_d;
      held_idx_q <= held_idx_d;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed table, corner sequences, random vs queue model.
module tb_issue_queue;
  import typedefs::*;

  localparam int unsigned DEPTH = IQ_DEPTH;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  localparam rinstr_t    NoInstr = '0;
  localparam p_reg_t     NoWb    = '0;
  localparam br_result_t NoBr    = '0;

  logic            clk = 1'b0;
  logic            rst_i;
  rinstr_t         rinstr_i;
  p_reg_t          p_wb_i;
  br_result_t      br_result_i;
  logic            issue_ready_i;
  rinstr_t         iinstr_o;
  logic            iq_full_o;
  logic [CntW-1:0] iq_count_o;

  int checks  = 0;
  int errors  = 0;
  int dropped = 0;

  always #5 clk = ~clk;

  issue_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .rinstr_i      (rinstr_i),
    .p_wb_i        (p_wb_i),
    .br_result_i   (br_result_i),
    .issue_ready_i (issue_ready_i),
    .iinstr_o      (iinstr_o),
    .iq_full_o     (iq_full_o),
    .iq_count_o    (iq_count_o)
  );

  // Rename must stall on iq_full_o; an offer while full is a protocol error.
  always @(posedge clk) begin
    if (!rst_i && rinstr_i.valid && iq_full_o) begin
      dropped++;
      $display("protocol error: rinstr_i.valid while iq_full_o at %0t", $time);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    rinstr_t   rin;
    p_reg_t    wb;
    logic      rdy;
    logic      exp_v;
    preg_idx_t exp_rd;
    int        exp_cnt;
  } vec_t;

  function automatic rinstr_t mk(input preg_idx_t rd, input logic [15:0] imm,
                                 input logic s1v, input logic s1r, input preg_idx_t s1i,
                                 input logic s2v, input logic s2r, input preg_idx_t s2i);
    rinstr_t r;
    r           = '0;
    r.valid     = 1'b1;
    r.rd        = rd;
    r.imm       = imm;
    r.rs1.valid = s1v;
    r.rs1.ready = s1r;
    r.rs1.idx   = s1i;
    r.rs2.valid = s2v;
    r.rs2.ready = s2r;
    r.rs2.idx   = s2i;
    return r;
  endfunction

  function automatic p_reg_t wbi(input logic v, input preg_idx_t idx);
    p_reg_t w;
    w.valid = v;
    w.idx   = idx;
    return w;
  endfunction

  function automatic vec_t row(input rinstr_t rin, input p_reg_t wb, input logic rdy,
                               input logic ev, input preg_idx_t erd, input int ecnt);
    vec_t v;
    v.rin = rin; v.wb = wb; v.rdy = rdy; v.exp_v = ev; v.exp_rd = erd; v.exp_cnt = ecnt;
    return v;
  endfunction

  function automatic br_result_t br(input logic v, input logic h);
    br_result_t b;
    b.valid = v;
    b.hit   = h;
    return b;
  endfunction

  // Model rules: a source is usable when unused or ready; wakeup sets ready on a match.
  function automatic logic m_ok(input rinstr_t e);
    return (!e.rs1.valid || e.rs1.ready) && (!e.rs2.valid || e.rs2.ready);
  endfunction

  function automatic rinstr_t m_wake(input rinstr_t e, input p_reg_t wb);
    rinstr_t r;
    r = e;
    if (wb.valid && e.rs1.valid && e.rs1.idx == wb.idx) r.rs1.ready = 1'b1;
    if (wb.valid && e.rs2.valid && e.rs2.idx == wb.idx) r.rs2.ready = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then let combinational outputs settle before sampling.
  task automatic step(input rinstr_t rin, input p_reg_t wb, input br_result_t b, input logic rdy);
    @(negedge clk);
    rinstr_i      = rin;
    p_wb_i        = wb;
    br_result_i   = b;
    issue_ready_i = rdy;
    #1;
  endtask

  vec_t      vecs [22];
  int        order [8] = '{1, 0, 2, 3, 4, 5, 6, 7};
  rinstr_t   q [$];
  rinstr_t   r;
  p_reg_t    w;
  br_result_t b;
  logic      rdy, flush, held_v;
  logic [15:0] held_imm, next_imm;
  int        k, size_before, model_iss, dut_iss;

  initial begin
    rst_i = 1'b1; rinstr_i = NoInstr; p_wb_i = NoWb; br_result_i = NoBr; issue_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_iinstr", 64'(iinstr_o), 0);
    chk("reset_full", iq_full_o, 0);
    chk("reset_count", iq_count_o, 0);
    @(negedge clk);
    rst_i = 1'b0;

    // Directed single-cycle table: each row is one clock of stimulus and sampled outputs.
    vecs[0]  = row(mk(6'd40, 16'd1, 1, 1, 6'd3, 0, 0, 6'd0), NoWb, 1, 0, 6'd0, 0);
    vecs[1]  = row(NoInstr, NoWb, 1, 1, 6'd40, 1);
    vecs[2]  = row(NoInstr, NoWb, 1, 0, 6'd0, 0);
    vecs[3]  = row(mk(6'd10, 16'd2, 1, 0, 6'd33, 0, 0, 6'd0), NoWb, 1, 0, 6'd0, 0);
    vecs[4]  = row(mk(6'd11, 16'd3, 1, 1, 6'd5, 0, 0, 6'd0), NoWb, 1, 0, 6'd0, 1);
    vecs[5]  = row(NoInstr, wbi(1, 6'd33), 1, 1, 6'd11, 2);
    vecs[6]  = row(NoInstr, NoWb, 1, 1, 6'd10, 1);
    vecs[7]  = row(NoInstr, NoWb, 1, 0, 6'd0, 0);
    vecs[8]  = row(mk(6'd12, 16'd4, 0, 0, 6'd0, 1, 0, 6'd50), wbi(1, 6'd50), 1, 0, 6'd0, 0);
    vecs[9]  = row(NoInstr, NoWb, 1, 1, 6'd12, 1);
    vecs[10] = row(NoInstr, NoWb, 1, 0, 6'd0, 0);
    vecs[11] = row(mk(6'd13, 16'd5, 1, 0, 6'd20, 0, 0, 6'd0), wbi(0, 6'd20), 1, 0, 6'd0, 0);
    vecs[12] = row(NoInstr, wbi(1, 6'd21), 1, 0, 6'd0, 1);
    vecs[13] = row(NoInstr, wbi(1, 6'd20), 1, 0, 6'd0, 1);
    vecs[14] = row(NoInstr, NoWb, 1, 1, 6'd13, 1);
    vecs[15] = row(NoInstr, NoWb, 1, 0, 6'd0, 0);
    vecs[16] = row(mk(6'd14, 16'd6, 1, 0, 6'd7, 0, 0, 6'd0), NoWb, 1, 0, 6'd0, 0);
    vecs[17] = row(mk(6'd15, 16'd7, 0, 0, 6'd0, 1, 0, 6'd7), NoWb, 1, 0, 6'd0, 1);
    vecs[18] = row(NoInstr, wbi(1, 6'd7), 1, 0, 6'd0, 2);
    vecs[19] = row(NoInstr, NoWb, 1, 1, 6'd14, 2);
    vecs[20] = row(NoInstr, NoWb, 1, 1, 6'd15, 1);
    vecs[21] = row(NoInstr, NoWb, 1, 0, 6'd0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rin, vecs[i].wb, NoBr, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), iinstr_o.valid, vecs[i].exp_v);
      if (vecs[i].exp_v) chk($sformatf("vec%0d_rd", i), iinstr_o.rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_count", i), iq_count_o, vecs[i].exp_cnt);
    end

    // Fill to full with the oldest entry blocked, then hold the offer under backpressure.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i == 0) r = mk(6'd0, 16'd100, 1, 0, 6'd60, 0, 0, 6'd0);
      else        r = mk(6'(i), 16'(100 + i), 0, 0, 6'd0, 0, 0, 6'd0);
      step(r, NoWb, NoBr, 0);
      chk("fill_count", iq_count_o, i);
      chk("fill_full", iq_full_o, 0);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 0) step(mk(6'd9, 16'd200, 0, 0, 6'd0, 0, 0, 6'd0), wbi(1, 6'd60), NoBr, 0);
      else        step(NoInstr, NoWb, NoBr, 0);
      chk("full_flag", iq_full_o, 1);
      chk("full_count", iq_count_o, DEPTH);
      chk("hold_valid", iinstr_o.valid, 1);
      chk("hold_rd", iinstr_o.rd, 1);
    end
    chk("dropped_when_full", dropped, 1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      step(NoInstr, NoWb, NoBr, 1);
      chk("drain_valid", iinstr_o.valid, 1);
      chk("drain_rd", iinstr_o.rd, order[i]);
      chk("drain_count", iq_count_o, int'(DEPTH) - i);
    end
    step(NoInstr, NoWb, NoBr, 1);
    chk("drained_valid", iinstr_o.valid, 0);
    chk("drained_count", iq_count_o, 0);

    // Mispredict flush with a concurrent allocation, then a hit / invalid result with no effect.
    for (int i = 0; i < 5; i++) step(mk(6'(20 + i), 16'(300 + i), 0, 0, 0, 0, 0, 0), NoWb, NoBr, 0);
    step(mk(6'd30, 16'd310, 0, 0, 0, 0, 0, 0), NoWb, br(1, 0), 1);
    chk("flush_cycle_valid", iinstr_o.valid, 0);
    chk("flush_cycle_count", iq_count_o, 5);
    step(NoInstr, NoWb, NoBr, 0);
    chk("post_flush_count", iq_count_o, 0);
    chk("post_flush_valid", iinstr_o.valid, 0);
    for (int i = 0; i < 5; i++) step(mk(6'(20 + i), 16'(320 + i), 0, 0, 0, 0, 0, 0), NoWb, NoBr, 0);
    step(NoInstr, NoWb, br(1, 1), 0);
    chk("hit_valid", iinstr_o.valid, 1);
    chk("hit_rd", iinstr_o.rd, 20);
    chk("hit_count", iq_count_o, 5);
    step(NoInstr, NoWb, br(0, 0), 0);
    chk("post_hit_count", iq_count_o, 5);
    step(NoInstr, NoWb, NoBr, 0);
    chk("post_nobr_count", iq_count_o, 5);

    // Reset mid-operation discards everything.
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    #1;
    chk("midreset_count", iq_count_o, 0);
    chk("midreset_iinstr", 64'(iinstr_o), 0);
    chk("midreset_full", iq_full_o, 0);

    // Randomised run against an in-order queue model.
    held_v = 1'b0; held_imm = '0; next_imm = 16'd1000; model_iss = 0; dut_iss = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      r = NoInstr;
      if (q.size() < int'(DEPTH) && $urandom_range(0, 2) != 0) begin
        r = mk(6'($urandom_range(0, 63)), next_imm,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)));
        next_imm++;
      end
      w = NoWb;
      if ($urandom_range(0, 1) != 0) w = wbi(1, 6'($urandom_range(0, 7)));
      b = NoBr;
      if ($urandom_range(0, 39) == 0) b = br(1, 1'($urandom_range(0, 1)));
      rdy = ($urandom_range(0, 9) < 6);
      step(r, w, b, rdy);

      flush = b.valid && !b.hit;
      k = -1;
      if (!flush) begin
        if (held_v) begin
          foreach (q[j]) if (q[j].imm == held_imm) k = j;
          chk("rand_held_present", (k >= 0), 1);
        end else begin
          foreach (q[j]) if (k < 0 && m_ok(q[j])) k = j;
        end
      end
      chk("rand_count", iq_count_o, q.size());
      chk("rand_full", iq_full_o, (q.size() == int'(DEPTH)));
      chk("rand_valid", iinstr_o.valid, (k >= 0));
      if (k >= 0) begin
        chk("rand_imm", iinstr_o.imm, q[k].imm);
        chk("rand_rd", iinstr_o.rd, q[k].rd);
      end
      if (iinstr_o.valid) chk("rand_src_ready", m_ok(iinstr_o), 1);
      if (iinstr_o.valid && rdy) dut_iss++;

      size_before = q.size();
      if (flush) begin
        q.delete();
        held_v = 1'b0;
      end else begin
        foreach (q[j]) q[j] = m_wake(q[j], w);
        if (k >= 0 && rdy) begin
          q.delete(k);
          held_v = 1'b0;
          model_iss++;
        end else if (k >= 0) begin
          held_v   = 1'b1;
          held_imm = q[k].imm;
        end else begin
          held_v = 1'b0;
        end
        if (r.valid && size_before < int'(DEPTH)) q.push_back(m_wake(r, w));
      end
    end
    chk("rand_issue_total", dut_iss, model_iss);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
